// File: rtl/nn_layer_sequencer_pkg.sv
// Shared definitions for the fully-connected layer sequencer: FSM state
// encoding and default datapath widths.
package nn_layer_sequencer_pkg;

  // Sequencer states; the encoding is also exported on the dbg_state port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ACC_WIDTH = 16;

endpackage

// File: rtl/nn_layer_sequencer_mac.sv
// Signed multiply-accumulate with saturation. The product of two WIDTH-bit
// operands is sign-extended to the accumulator and added; any overflow
// clamps to the most positive or most negative accumulator value.
module nn_mac_unit #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  localparam int PW = 2 * WIDTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]    prod;
  logic [ACC_WIDTH:0]      sum;
  logic [ACC_WIDTH-1:0]    sat;

  // Full-precision product, one guard bit of sum, then clamp on overflow.
  always_comb begin
    prod = PW'(a) * PW'(b);
    sum  = {acc[ACC_WIDTH-1], acc} +
           {{(ACC_WIDTH+1-PW){prod[PW-1]}}, prod};
    sat  = sum[ACC_WIDTH-1:0];
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      sat = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  // Accumulator register; clear wins over a qualified accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sat;
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Sequences one fully-connected layer: for each output neuron, streams
// IN_DEPTH activation/weight pairs through the MAC, then writes the
// saturated sum to the output RAM at the neuron index.
//
// Control handshake: start is sampled only in IDLE; busy is high while the
// layer runs (FETCH/DRAIN/WRITE); done pulses for one cycle at completion.
// A start seen in any other state is dropped, never queued.
module nn_layer_sequencer
  import nn_layer_sequencer_pkg::*;
#(
  parameter int IN_DEPTH  = 784,
  parameter int NEURONS   = 10,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  localparam int AW  = $clog2(IN_DEPTH),
  localparam int WAW = $clog2(NEURONS * IN_DEPTH),
  localparam int NW  = $clog2(NEURONS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [AW-1:0]               act_addr,
  input  logic signed [WIDTH-1:0]     act_data,
  output logic [WAW-1:0]              w_addr,
  input  logic signed [WIDTH-1:0]     w_data,
  output logic                        out_wen,
  output logic [NW-1:0]               out_addr,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output state_t                      dbg_state
);

  state_t         state;
  state_t         state_next;
  logic [NW-1:0]  neuron;
  logic           rd_valid;
  logic           mac_clr;
  logic           last_i;
  logic           last_n;
  logic signed [ACC_WIDTH-1:0] acc;

  assign last_i    = (act_addr == AW'(IN_DEPTH - 1));
  assign last_n    = (neuron == NW'(NEURONS - 1));
  assign out_addr  = neuron;
  assign out_data  = acc;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    out_wen    = 1'b0;
    mac_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          mac_clr    = 1'b1;
        end
      end
      ST_FETCH: begin
        busy = 1'b1;
        if (last_i) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        busy       = 1'b1;
        out_wen    = 1'b1;
        mac_clr    = 1'b1;
        state_next = last_n ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address counters, neuron index and the 1-cycle read-valid delay.
  // w_addr keeps counting across neurons so no multiplier is needed;
  // the step into the next neuron happens on the WRITE->FETCH edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_addr <= '0;
      w_addr   <= '0;
      neuron   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state == ST_FETCH);
      case (state)
        ST_IDLE: begin
          if (start) begin
            act_addr <= '0;
            w_addr   <= '0;
            neuron   <= '0;
          end
        end
        ST_FETCH: begin
          if (!last_i) begin
            act_addr <= act_addr + AW'(1);
            w_addr   <= w_addr + WAW'(1);
          end
        end
        ST_WRITE: begin
          if (!last_n) begin
            act_addr <= '0;
            w_addr   <= w_addr + WAW'(1);
            neuron   <= neuron + NW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  nn_mac_unit #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (rd_valid),
    .a   (act_data),
    .b   (w_data),
    .acc (acc)
  );

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer with IN_DEPTH=4, NEURONS=2. Two instances
// share memories and control: one with a 16-bit accumulator, one with an
// 8-bit accumulator so saturation is reachable with 4-bit operands.
module tb_nn_layer_sequencer;
  import nn_layer_sequencer_pkg::*;

  localparam int D = 4;
  localparam int N = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              d16_busy, d16_done, d16_out_wen;
  logic [1:0]        d16_act_addr;
  logic [2:0]        d16_w_addr;
  logic [0:0]        d16_out_addr;
  logic signed [15:0] d16_out_data;
  logic signed [3:0] d16_act_data, d16_w_data;
  state_t            d16_state;

  logic              d8_busy, d8_done, d8_out_wen;
  logic [1:0]        d8_act_addr;
  logic [2:0]        d8_w_addr;
  logic [0:0]        d8_out_addr;
  logic signed [7:0] d8_out_data;
  logic signed [3:0] d8_act_data, d8_w_data;
  state_t            d8_state;

  nn_layer_sequencer #(.IN_DEPTH(D), .NEURONS(N), .WIDTH(4), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .busy(d16_busy), .done(d16_done),
    .act_addr(d16_act_addr), .act_data(d16_act_data),
    .w_addr(d16_w_addr), .w_data(d16_w_data),
    .out_wen(d16_out_wen), .out_addr(d16_out_addr), .out_data(d16_out_data),
    .dbg_state(d16_state)
  );

  nn_layer_sequencer #(.IN_DEPTH(D), .NEURONS(N), .WIDTH(4), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .busy(d8_busy), .done(d8_done),
    .act_addr(d8_act_addr), .act_data(d8_act_data),
    .w_addr(d8_w_addr), .w_data(d8_w_data),
    .out_wen(d8_out_wen), .out_addr(d8_out_addr), .out_data(d8_out_data),
    .dbg_state(d8_state)
  );

  // ---------------- registered memory models ----------------
  logic signed [3:0] act_mem[D];
  logic signed [3:0] w_mem[N*D];

  always @(posedge clk) begin
    d16_act_data <= act_mem[d16_act_addr];
    d16_w_data   <= w_mem[d16_w_addr];
    d8_act_data  <= act_mem[d8_act_addr];
    d8_w_data    <= w_mem[d8_w_addr];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [16:0] exp16_q[$];
  logic [8:0]  exp8_q[$];
  int writes16, writes8, done16_cnt, done8_cnt;
  logic signed [15:0] last16;
  logic signed [7:0]  last8;

  // Each output write is popped against the expected {addr, data} queue.
  always @(negedge clk) begin
    logic [16:0] e16;
    logic [8:0]  e8;
    if (d16_out_wen === 1'b1) begin
      writes16++;
      last16 = d16_out_data;
      checks++;
      if (exp16_q.size() == 0) begin
        errors++;
        $display("FAIL wr16_unexpected: got %0h expected none", {d16_out_addr, d16_out_data});
      end else begin
        e16 = exp16_q.pop_front();
        if ({d16_out_addr, d16_out_data} !== e16) begin
          errors++;
          $display("FAIL wr16: got %0h expected %0h", {d16_out_addr, d16_out_data}, e16);
        end
      end
    end
    if (d8_out_wen === 1'b1) begin
      writes8++;
      last8 = d8_out_data;
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL wr8_unexpected: got %0h expected none", {d8_out_addr, d8_out_data});
      end else begin
        e8 = exp8_q.pop_front();
        if ({d8_out_addr, d8_out_data} !== e8) begin
          errors++;
          $display("FAIL wr8: got %0h expected %0h", {d8_out_addr, d8_out_data}, e8);
        end
      end
    end
    if (d16_done === 1'b1) done16_cnt++;
    if (d8_done === 1'b1) done8_cnt++;
  end

  // ---------------- reference model ----------------
  // Dot product with clamping after every accumulate step.
  function automatic int ref_neuron(int n, int accw);
    int acc;
    int hi;
    int lo;
    acc = 0;
    hi  = (1 << (accw - 1)) - 1;
    lo  = -(1 << (accw - 1));
    for (int i = 0; i < D; i++) begin
      acc = acc + int'(act_mem[i]) * int'(w_mem[n*D + i]);
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
    end
    return acc;
  endfunction

  task automatic load_expect(input int nmax);
    int r;
    exp16_q.delete();
    exp8_q.delete();
    for (int n = 0; n < nmax; n++) begin
      r = ref_neuron(n, 16);
      exp16_q.push_back({1'(n), 16'(r)});
      r = ref_neuron(n, 8);
      exp8_q.push_back({1'(n), 8'(r)});
    end
    writes16 = 0; writes8 = 0; done16_cnt = 0; done8_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_mem(input int a, input int w);
    for (int i = 0; i < D; i++) act_mem[i] = 4'(a);
    for (int i = 0; i < N*D; i++) w_mem[i] = 4'(w);
  endtask

  task automatic set_mem_random();
    for (int i = 0; i < D; i++) act_mem[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < N*D; i++) w_mem[i] = 4'($urandom_range(0, 15));
  endtask

  // Pulse start, then watch 40 cycles counted from the accept edge.
  // Sample c is the falling edge c half-cycles... i.e. inside cycle c.
  // pulse_a/pulse_b re-assert start during those cycles; rst_at > 0
  // asserts reset in that cycle and releases it two cycles later.
  task automatic run_layer(input int pulse_a, input int pulse_b,
                           input int rst_at, output int lat);
    int n;
    int k;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rst_at == 0 || c < rst_at) begin
        n = (c - 1) / (D + 2);
        k = (c - 1) % (D + 2);
        checks++;
        if (d16_busy !== (c <= N*(D+2))) begin
          errors++;
          $display("FAIL busy c=%0d: got %0b expected %0b", c, d16_busy, (c <= N*(D+2)));
        end
        if (c <= N*(D+2) && k < D) begin
          checks++;
          if (d16_act_addr !== 2'(k) || d16_w_addr !== 3'(n*D + k)) begin
            errors++;
            $display("FAIL addr c=%0d: got act=%0d w=%0d expected act=%0d w=%0d",
                     c, d16_act_addr, d16_w_addr, k, n*D + k);
          end
        end
      end
      if (d16_done === 1'b1 && lat < 0) lat = c;
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if (d16_busy !== 1'b0 || d16_out_wen !== 1'b0 || d16_state !== ST_IDLE || d8_busy !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid: got busy=%0b wen=%0b state=%0d expected 0 0 %0d",
                   d16_busy, d16_out_wen, d16_state, ST_IDLE);
        end
      end
      if (rst_at > 0 && c == rst_at + 2) rst = 1'b0;
      start = (c == pulse_a || c == pulse_b);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_mem(0, 0);
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (d16_busy !== 0 || d16_done !== 0 || d16_out_wen !== 0 || d16_act_addr !== 0 ||
        d16_w_addr !== 0 || d16_out_addr !== 0 || d16_out_data !== 0 || d16_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset16: got busy=%0b done=%0b wen=%0b aa=%0d wa=%0d oa=%0d od=%0d expected all 0",
               d16_busy, d16_done, d16_out_wen, d16_act_addr, d16_w_addr, d16_out_addr, d16_out_data);
    end
    checks++;
    if (d8_busy !== 0 || d8_done !== 0 || d8_out_wen !== 0 || d8_out_data !== 0) begin
      errors++;
      $display("FAIL reset8: got busy=%0b done=%0b wen=%0b od=%0d expected all 0",
               d8_busy, d8_done, d8_out_wen, d8_out_data);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (d16_state !== ST_IDLE || d16_busy !== 0 || d16_out_wen !== 0 || d16_done !== 0) begin
        errors++;
        $display("FAIL idle_hold c=%0d: got state=%0d busy=%0b expected %0d 0", c, d16_state, d16_busy, ST_IDLE);
      end
    end
  endtask

  task automatic check_run(input string name, input int lat, input int exp_lat, input int exp_writes);
    // Inline end-of-run bookkeeping for one scenario.
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (writes16 !== exp_writes || writes8 !== exp_writes || exp16_q.size() != 0 || exp8_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes: got %0d/%0d left %0d/%0d expected %0d left 0",
               name, writes16, writes8, exp16_q.size(), exp8_q.size(), exp_writes);
    end
    checks++;
    if (done16_cnt !== (exp_lat > 0 ? 1 : 0) || done8_cnt !== done16_cnt) begin
      errors++;
      $display("FAIL %s_done_count: got %0d/%0d expected %0d", name, done16_cnt, done8_cnt, (exp_lat > 0 ? 1 : 0));
    end
  endtask

  task automatic test_basic();
    int lat;
    set_mem(1, 1);
    load_expect(N);
    run_layer(0, 0, 0, lat);
    check_run("basic", lat, N*(D+2)+1, N);
    checks++;
    if (last16 !== 16'sd4) begin
      errors++;
      $display("FAIL basic_value: got %0d expected 4", last16);
    end
  endtask

  task automatic test_values();
    int lat;
    set_mem(-8, 7);
    load_expect(N);
    run_layer(0, 0, 0, lat);
    check_run("neg", lat, N*(D+2)+1, N);
    checks++;
    if (last16 !== -16'sd224) begin
      errors++;
      $display("FAIL neg_value: got %0d expected -224", last16);
    end
    set_mem(1, 7);
    for (int i = 0; i < D; i++) w_mem[D + i] = 4'(i + 1);
    load_expect(N);
    run_layer(0, 0, 0, lat);
    check_run("ramp", lat, N*(D+2)+1, N);
    checks++;
    if (last16 !== 16'sd10) begin
      errors++;
      $display("FAIL ramp_value: got %0d expected 10", last16);
    end
  endtask

  task automatic test_saturation();
    int lat;
    set_mem(-8, -8);
    load_expect(N);
    run_layer(0, 0, 0, lat);
    check_run("sat_pos", lat, N*(D+2)+1, N);
    checks++;
    if (last8 !== 8'sd127 || last16 !== 16'sd256) begin
      errors++;
      $display("FAIL sat_pos_value: got %0d/%0d expected 127/256", last8, last16);
    end
    // Most negative reachable product with 4-bit operands: -8 * 7.
    set_mem(-8, 7);
    load_expect(N);
    run_layer(0, 0, 0, lat);
    check_run("sat_neg", lat, N*(D+2)+1, N);
    checks++;
    if (last8 !== -8'sd128) begin
      errors++;
      $display("FAIL sat_neg_value: got %0d expected -128", last8);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    set_mem_random();
    load_expect(N);
    run_layer(2, N*(D+2)+1, 0, lat);
    check_run("ignore_start", lat, N*(D+2)+1, N);
    checks++;
    if (d16_state !== ST_IDLE || d16_busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle: got state=%0d busy=%0b expected %0d 0", d16_state, d16_busy, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    set_mem_random();
    load_expect(1);
    run_layer(0, 0, D + 3, lat);
    check_run("rst_mid", lat, -1, 1);
    load_expect(N);
    run_layer(0, 0, 0, lat);
    check_run("after_rst", lat, N*(D+2)+1, N);
  endtask

  task automatic test_random();
    int lat;
    for (int it = 0; it < 8; it++) begin
      set_mem_random();
      load_expect(N);
      run_layer(0, 0, 0, lat);
      check_run("random", lat, N*(D+2)+1, N);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_basic();
    test_values();
    test_saturation();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
